pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- id_rs  in  5  ID-stage source register A address.
- id_rt  in  5  ID-stage source register B address.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ewreg  in  1  EXE-stage instruction writes the register file.
- em2reg  in  1  EXE-stage instruction is a load.
- ereg_addr  in  5  EXE-stage destination register.
- mwreg  in  1  MEM-stage instruction writes the register file.
- mm2reg  in  1  MEM-stage instruction is a load.
- mreg_addr  in  5  MEM-stage destination register.
- branch_taken  in  1  branch resolved taken in ID.
- stall  out  1  hold PC and IF/ID register.
- bubble  out  1  force the ID/EXE register write, load-select and mem-write controls to 0 this cycle.
- flush_ifid  out  1  clear IF/ID to a nop.
- fwd_a  out  2  SrcA select: 00 regfile, 01 EXE ALU result, 10 MEM result.
- fwd_b  out  2  SrcB select, same encoding as fwd_a.
- stall_cnt  out  16  total stall cycles since reset.

Function
REQ-002 A match on a source SHALL require all of: use flag=1, address equal to the stage destination, stage write flag=1, and address not 0.
REQ-003 The FSM SHALL have two states. RUN is the reset state. STALL holds a 2-bit remaining-stall register rem.
REQ-004 In RUN, when a hazard needs N stall cycles (N≥1), the block SHALL assert stall=1 and bubble=1 in that same cycle (combinational from inputs).
- If N=1, the FSM stays in RUN.
- If N>1, the next state is STALL with rem=N-1.
REQ-005 In STALL, the block SHALL assert stall=1 and bubble=1 regardless of inputs. rem decrements each cycle, and the FSM returns to RUN on the cycle after rem=1.
REQ-006 In RUN with no hazard, stall and bubble SHALL be 0.
REQ-007 flush_ifid SHALL equal branch_taken only when the state is RUN and no hazard is detected. branch_taken SHALL be ignored while a stall is in progress, because the ID operands are stale.
REQ-008 When an rs hazard and an rt hazard occur together, N SHALL be the maximum of the two requirements.
REQ-009 stall_cnt SHALL increment by 1 on every clock edge where stall=1, and SHALL saturate at 16'hFFFF.
REQ-010 fwd_a and fwd_b SHALL be 00 whenever stall=1 or FORWARD_EN is undefined.
REQ-011 There SHALL be no output latency beyond REQ-004/005: all outputs are combinational from state, rem and inputs, and the state is registered.

Reset
REQ-012 While rst=1 the block SHALL force the following, with rst taking effect immediately and asynchronously:
- state=RUN, rem=0, stall_cnt=0.
- stall=0, bubble=0, flush_ifid=0, fwd_a=00, fwd_b=00.
REQ-013 rst asserted during STALL SHALL abort the stall. The first cycle after release SHALL evaluate inputs as in RUN.

Configuration
REQ-014 Macro FORWARD_EN defined selects forwarding mode:
- EXE match with em2reg=1 gives N=1 (load-use).
- EXE match with em2reg=0 gives no stall and fwd=01.
- Otherwise, a MEM match gives fwd=10.
- An EXE match takes priority over a MEM match for the same source.
REQ-015 Macro FORWARD_EN undefined selects stall-only mode:
- EXE match gives N=2.
- Otherwise, a MEM match gives N=1.
- fwd_a and fwd_b are constant 00, and the STALL state is reachable.

Verification
REQ-016 A bench SHALL cover these directed scenarios:
- FORWARD_EN defined, ewreg=1, em2reg=0, ereg_addr=5, id_rs=5, id_use_rs=1 -> fwd_a=01, stall=0, stall_cnt unchanged.
- FORWARD_EN defined, load in EXE (em2reg=1, ereg_addr=8), id_rt=8 used -> one cycle of stall=1 and bubble=1; next cycle the load is in MEM with mm2reg=1 and fwd_b=10, stall_cnt=1.
- FORWARD_EN undefined, EXE match on rs=3 -> stall=1 for exactly 2 consecutive cycles (RUN then STALL rem=1), then RUN; stall_cnt=2.
- Destination 0 in EXE and MEM with id_rs=id_rt=0 -> no stall, fwd=00 in both modes.
- branch_taken=1 on a no-hazard cycle -> flush_ifid=1 for one cycle; branch_taken=1 during a STALL cycle -> flush_ifid=0.
- rst pulsed mid-STALL (stall-only mode) -> stall=0 and stall_cnt=0 immediately; the 16'hFFFF saturation is checked by holding a hazard for 65540 cycles.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stall FSM, operand forwarding selects, stall counter.
// Define FORWARD_EN for forwarding mode; leave it undefined for stall-only mode.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic [4:0]  ereg_addr,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic [4:0]  mreg_addr,
  input  logic        branch_taken,
  output logic        stall,
  output logic        bubble,
  output logic        flush_ifid,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  rem_reg, rem_next;
  logic [15:0] cnt_reg;

  logic [4:0]  src_addr [2];
  logic        src_use  [2];
  logic        e_match  [2];
  logic        m_match  [2];
  logic [1:0]  need_src [2];
  logic [1:0]  fwd_src  [2];
  logic [1:0]  hazard_n;
  logic        stall_c;
  logic        flush_c;

  // mm2reg never changes the decision: MEM data (ALU or load) is forwarded the same way.
  logic unused_inputs;
  assign unused_inputs = mm2reg;

  assign src_addr[0] = id_rs;
  assign src_addr[1] = id_rt;
  assign src_use[0]  = id_use_rs;
  assign src_use[1]  = id_use_rt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign e_match[gi] = src_use[gi] && ewreg && (src_addr[gi] == ereg_addr) && (src_addr[gi] != 5'd0);
      assign m_match[gi] = src_use[gi] && mwreg && (src_addr[gi] == mreg_addr) && (src_addr[gi] != 5'd0);

`ifdef FORWARD_EN
      always_comb begin
        need_src[gi] = 2'd0;
        fwd_src[gi]  = 2'b00;
        if (e_match[gi]) begin
          if (em2reg) need_src[gi] = 2'd1;
          else        fwd_src[gi]  = 2'b01;
        end else if (m_match[gi]) begin
          fwd_src[gi] = 2'b10;
        end
      end
`else
      always_comb begin
        need_src[gi] = 2'd0;
        fwd_src[gi]  = 2'b00;
        if (e_match[gi])      need_src[gi] = 2'd2;
        else if (m_match[gi]) need_src[gi] = 2'd1;
      end
`endif
    end
  endgenerate

`ifndef FORWARD_EN
  logic unused_load_flag;
  assign unused_load_flag = em2reg;
`endif

  assign hazard_n = (need_src[0] > need_src[1]) ? need_src[0] : need_src[1];

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    stall_c    = 1'b0;
    flush_c    = 1'b0;
    case (state_reg)
      RUN: begin
        if (hazard_n != 2'd0) begin
          stall_c = 1'b1;
          if (hazard_n > 2'd1) begin
            state_next = STALL;
            rem_next   = hazard_n - 2'd1;
          end
        end else begin
          flush_c = branch_taken;
        end
      end
      STALL: begin
        // ID operands are stale here, so inputs (including branch_taken) are ignored.
        stall_c = 1'b1;
        if (rem_reg <= 2'd1) begin
          state_next = RUN;
          rem_next   = 2'd0;
        end else begin
          rem_next = rem_reg - 2'd1;
        end
      end
      default: begin
        state_next = RUN;
        rem_next   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
      rem_reg   <= 2'd0;
      cnt_reg   <= 16'd0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      if (stall_c && (cnt_reg != 16'hFFFF)) cnt_reg <= cnt_reg + 16'd1;
    end
  end

  // Outputs are gated by rst so they drop the instant reset is asserted.
  assign stall      = stall_c & ~rst;
  assign bubble     = stall_c & ~rst;
  assign flush_ifid = flush_c & ~rst;
  assign fwd_a      = (stall_c || rst) ? 2'b00 : fwd_src[0];
  assign fwd_b      = (stall_c || rst) ? 2'b00 : fwd_src[1];
  assign stall_cnt  = cnt_reg;

endmodule
